// File: rtl/ras_pkg.sv
// Shared types and address decode for the RAS spill responder.
// Byte addresses are rebased and converted to word indices here.
package ras_pkg;

   typedef enum logic [0:0] {
      RSP_IDLE  = 1'b0,
      RSP_CLEAR = 1'b1
   } rsp_state_t;

   localparam int RAS_WORD_BYTES = 4;

   typedef struct packed {
      logic        in_range;
      logic [31:0] idx;
   } ras_idx_t;

   // Offset wraps at 32 bits, so addresses below base land far out of range.
   function automatic ras_idx_t addr_to_idx(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
      ras_idx_t    r;
      logic [31:0] off;
      off        = addr - base;
      r.idx      = off / 32'(RAS_WORD_BYTES);
      r.in_range = ((off % 32'(RAS_WORD_BYTES)) == 32'd0) && (r.idx < depth);
      return r;
   endfunction

endpackage

// File: rtl/ras_spill_ram.sv
// Single-port synchronous RAM with registered read data and no reset.
// Read data reflects the contents before a same-edge write.
module ras_spill_ram #(
   parameter  int W     = 32,
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/ras_spill_responder.sv
// Memory-side responder for RAS spill traffic: word store with 1-cycle reads,
// sticky access-error flags, high-water mark and a whole-store zeroize.
module ras_spill_responder
   import ras_pkg::*;
#(
   parameter  int          W         = 32,
   parameter  int          DEPTH     = 256,
   parameter  logic [31:0] BASE_ADDR = 32'd0,
   localparam int          AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   // Handshake: a request is taken on a rising edge where mem_rdy=1 and exactly
   // one of mem_rd/mem_wr is high; nothing is queued while mem_rdy=0, and read
   // data appears on mem_dout the cycle after its accepting edge.
   input  logic          mem_rd,
   input  logic          mem_wr,
   input  logic [31:0]   mem_addr,
   input  logic [W-1:0]  mem_din,
   output logic [W-1:0]  mem_dout,
   output logic          mem_rdy,
   input  logic          clear_req,
   output logic          clear_busy,
   input  logic          err_clr,
   output logic          oob_err,
   output logic          proto_err,
   output logic [AW:0]   hwm,
   output rsp_state_t    dbg_state
);

   rsp_state_t    state, state_nxt;
   logic [AW-1:0] clear_ptr;
   logic          rdy_q;
   logic          rd_pend_q;
   logic [W-1:0]  dout_q;
   logic          oob_q, proto_q;
   logic [AW:0]   hwm_q;

   ras_idx_t      ai;
   logic          in_range;
   logic [AW-1:0] idx;
   logic [AW:0]   idx_p1;
   logic          acc, acc_rd_ok, acc_wr_ok, acc_bad, clash, clear_last;

   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [W-1:0]  ram_din, ram_dout;

   // Upper index bits are zero whenever the function reports in range; folding
   // them in keeps the decode self-consistent for any DEPTH.
   assign ai         = addr_to_idx(mem_addr, BASE_ADDR, 32'(DEPTH));
   assign in_range   = ai.in_range & ~|ai.idx[31:AW];
   assign idx        = ai.idx[AW-1:0];
   assign idx_p1     = {1'b0, idx} + {{AW{1'b0}}, 1'b1};

   assign acc        = rdy_q & (mem_rd ^ mem_wr);
   assign acc_rd_ok  = acc & mem_rd & in_range;
   assign acc_wr_ok  = acc & mem_wr & in_range;
   assign acc_bad    = acc & ~in_range;
   assign clash      = rdy_q & mem_rd & mem_wr;
   assign clear_last = (state == RSP_CLEAR) && (clear_ptr == AW'(DEPTH - 1));

   always_comb begin
      state_nxt = state;
      ram_we    = acc_wr_ok;
      ram_addr  = idx;
      ram_din   = mem_din;
      case (state)
         RSP_IDLE: begin
            if (clear_req) state_nxt = RSP_CLEAR;
         end
         RSP_CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = clear_ptr;
            ram_din  = '0;
            if (clear_last) state_nxt = RSP_IDLE;
         end
         default: state_nxt = RSP_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RSP_IDLE;
         rdy_q     <= 1'b0;
         clear_ptr <= '0;
         rd_pend_q <= 1'b0;
         dout_q    <= '0;
         oob_q     <= 1'b0;
         proto_q   <= 1'b0;
         hwm_q     <= '0;
      end else begin
         state     <= state_nxt;
         rdy_q     <= (state_nxt == RSP_IDLE);
         rd_pend_q <= acc_rd_ok;

         if (state == RSP_IDLE && clear_req) clear_ptr <= '0;
         else if (state == RSP_CLEAR)        clear_ptr <= clear_ptr + 1'b1;

         // dout_q holds the last delivered word once the RAM port moves on.
         if (clear_last || (acc_bad && mem_rd)) dout_q <= '0;
         else if (rd_pend_q)                    dout_q <= ram_dout;

         if (clear_last)                        hwm_q <= '0;
         else if (acc_wr_ok && idx_p1 > hwm_q)  hwm_q <= idx_p1;

         if (acc_bad)      oob_q <= 1'b1;
         else if (err_clr) oob_q <= 1'b0;

         if (clash)        proto_q <= 1'b1;
         else if (err_clr) proto_q <= 1'b0;
      end
   end

   ras_spill_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   assign mem_dout   = rd_pend_q ? ram_dout : dout_q;
   assign mem_rdy    = rdy_q;
   assign clear_busy = (state == RSP_CLEAR);
   assign oob_err    = oob_q;
   assign proto_err  = proto_q;
   assign hwm        = hwm_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_ras_spill_responder.sv
// Bench for ras_spill_responder: directed steps followed by randomized traffic,
// checked against a word-array reference model of the store.
module tb_ras_spill_responder;
   import ras_pkg::*;

   localparam int          W     = 32;
   localparam int          DEPTH = 16;
   localparam int          AW    = 4;
   localparam logic [31:0] BASE  = 32'd0;

   logic          clk, rst;
   logic          mem_rd, mem_wr, clear_req, err_clr;
   logic [31:0]   mem_addr;
   logic [W-1:0]  mem_din, mem_dout;
   logic          mem_rdy, clear_busy, oob_err, proto_err;
   logic [AW:0]   hwm;
   rsp_state_t    dbg_state;

   ras_spill_responder #(.W(W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .mem_rdy    (mem_rdy),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .err_clr    (err_clr),
      .oob_err    (oob_err),
      .proto_err  (proto_err),
      .hwm        (hwm),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model
   logic [31:0]  m_mem [DEPTH];
   bit           m_known [DEPTH];
   logic [31:0]  m_dout;
   bit           m_dout_known;
   bit           m_oob, m_proto, m_rdy;
   int           m_hwm;
   logic [W-1:0] exp_q[$];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_dout = '0; m_dout_known = 1'b1;
      m_oob = 1'b0; m_proto = 1'b0; m_hwm = 0; m_rdy = 1'b0;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_rdy"},   {31'd0, mem_rdy},   {31'd0, m_rdy});
      chk({tag, "_oob"},   {31'd0, oob_err},   {31'd0, m_oob});
      chk({tag, "_proto"}, {31'd0, proto_err}, {31'd0, m_proto});
      chk({tag, "_hwm"},   32'(hwm),           32'(m_hwm));
   endtask

   // driver: one request cycle plus model update and checks
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] din, input logic eclr);
      logic [31:0] off;
      bit          inr, acc;
      int          idx;
      off = addr - BASE;
      inr = (off % 4 == 0) && (off / 4 < DEPTH);
      idx = inr ? int'(off / 4) : 0;
      acc = m_rdy && (rd != wr);
      mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_din = din; err_clr = eclr;
      tick();
      mem_rd = 1'b0; mem_wr = 1'b0; err_clr = 1'b0;
      if (eclr) begin m_oob = 1'b0; m_proto = 1'b0; end
      if (m_rdy && rd && wr) m_proto = 1'b1;
      if (acc) begin
         if (!inr) begin
            m_oob = 1'b1;
            if (rd) begin m_dout = '0; m_dout_known = 1'b1; end
         end else if (wr) begin
            m_mem[idx] = din; m_known[idx] = 1'b1;
            if (idx + 1 > m_hwm) m_hwm = idx + 1;
         end else begin
            m_dout = m_mem[idx]; m_dout_known = m_known[idx];
         end
      end
      if (m_dout_known) begin
         exp_q.push_back(m_dout);
         chk({tag, "_dout"}, mem_dout, exp_q.pop_front());
      end
      check_status(tag);
   endtask

   // zeroize with ignored writes thrown at it while busy
   task automatic run_clear(input string tag);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      m_rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         chk({tag, "_busy_rdy"},  {31'd0, mem_rdy},    32'd0);
         chk({tag, "_busy_flag"}, {31'd0, clear_busy}, 32'd1);
         mem_wr   = 1'b1;
         mem_addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
         mem_din  = $urandom;
         tick();
      end
      mem_wr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b1; end
      m_rdy = 1'b1; m_hwm = 0; m_dout = '0; m_dout_known = 1'b1;
      chk({tag, "_end_busy"},  {31'd0, clear_busy}, 32'd0);
      chk({tag, "_end_state"}, 32'(dbg_state),      32'(RSP_IDLE));
      chk({tag, "_end_dout"},  mem_dout,            32'd0);
      check_status({tag, "_end"});
   endtask

   initial begin
      logic [31:0] a, d;
      int          sel;
      logic        rd, wr;

      rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_din = '0;
      clear_req = 1'b0; err_clr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end
      model_reset();

      // step 1: reset
      @(negedge clk);
      chk("rst_dout", mem_dout, 32'd0);
      check_status("rst");
      chk("rst_busy", {31'd0, clear_busy}, 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      chk("rel_rdy_low", {31'd0, mem_rdy}, 32'd0);
      tick();
      m_rdy = 1'b1;
      check_status("rel");

      // step 2: back-to-back writes and reads
      access("w0", 1'b0, 1'b1, 32'h0, 32'h11110000, 1'b0);
      access("w4", 1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0);
      access("r4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      chk("r4_val", mem_dout, 32'hDEADBEEF);
      access("r0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("r0_val", mem_dout, 32'h11110000);
      chk("hwm2", 32'(hwm), 32'd2);

      // step 3: out-of-range and misaligned
      access("r_wrap", 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0);
      chk("r_wrap_oob", {31'd0, oob_err}, 32'd1);
      access("w_hi",  1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0);
      access("w_mis", 1'b0, 1'b1, 32'h2,  32'h87654321, 1'b0);
      access("r0b",   1'b1, 1'b0, 32'h0,  32'h0, 1'b0);
      chk("r0b_val", mem_dout, 32'h11110000);
      access("eclr", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("eclr_oob", {31'd0, oob_err}, 32'd0);

      // step 4: rd and wr together
      access("w8",    1'b0, 1'b1, 32'h8, 32'h22222222, 1'b0);
      access("r4c",   1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      access("both8", 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
      chk("both8_hold", mem_dout, 32'hDEADBEEF);
      access("r8",    1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      chk("r8_old", mem_dout, 32'h22222222);
      access("eclr2", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

      // step 5: zeroize, then every word reads back 0
      run_clear("clr1");
      for (int i = 0; i < DEPTH; i++) access("clr1_rd", 1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);

      // step 6: reset at clear_ptr=5
      access("w_pre", 1'b0, 1'b1, 32'h3C, 32'hCAFEF00D, 1'b0);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (5) tick();
      chk("mid_state", 32'(dbg_state), 32'(RSP_CLEAR));
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, clear_busy}, 32'd0);
      chk("abort_rdy",  {31'd0, mem_rdy},    32'd0);
      chk("abort_dout", mem_dout,            32'd0);
      chk("abort_hwm",  32'(hwm),            32'd0);
      @(negedge clk);
      tick();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < DEPTH; i++) m_known[i] = (i < 5);
      tick();
      m_rdy = 1'b1;
      check_status("post_abort");
      access("pa_w", 1'b0, 1'b1, 32'h14, 32'h5A5A0001, 1'b0);
      chk("pa_hwm", 32'(hwm), 32'd6);
      access("pa_r", 1'b1, 1'b0, 32'h14, 32'h0, 1'b0);
      chk("pa_val", mem_dout, 32'h5A5A0001);

      // randomized traffic
      run_clear("clr2");
      for (int n = 0; n < 400; n++) begin
         if (n == 200) run_clear("clr3");
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = BASE + 32'($urandom_range(DEPTH, DEPTH + 100)) * 4;
         else if (sel == 1) a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         else               a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
         d   = $urandom;
         sel = $urandom_range(0, 19);
         rd  = (sel < 9) || (sel == 19);
         wr  = (sel >= 9 && sel < 18) || (sel == 19);
         access("rnd", rd, wr, a, d, ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
